// File: rtl/status_stack.sv
// Status flag register {V,C,N,Z} with a small LIFO save/restore stack used
// on interrupt entry/return. Stack misuse raises a sticky error bit.
module status_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  status_reset,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  carry_in,
  input  logic                  overflow_in,
  input  logic                  status_wr,
  input  logic [3:0]            wr_mask,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  err_clr,
  output logic                  flag_Z,
  output logic                  flag_N,
  output logic                  flag_C,
  output logic                  flag_V,
  output logic [CW-1:0]         stack_count,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);

  localparam int AW = $clog2(DEPTH);

  // Flag vector ordering matches wr_mask: bit0 = Z, bit1 = N, bit2 = C, bit3 = V
  logic [3:0]    flags;
  logic [3:0]    flags_next;
  logic [3:0]    cand;
  logic [3:0]    wr_en;
  logic [3:0]    stack_mem [DEPTH];
  logic [CW-1:0] count_next;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] pop_addr;
  logic          push_ok;
  logic          pop_ok;
  logic          err_set;

  assign stack_full  = (stack_count == CW'(DEPTH));
  assign stack_empty = (stack_count == '0);

  assign push_addr = AW'(stack_count);
  assign pop_addr  = AW'(stack_count - CW'(1));

  assign flag_Z = flags[0];
  assign flag_N = flags[1];
  assign flag_C = flags[2];
  assign flag_V = flags[3];

  // Decode stack operations, error conditions and the next flag/count values
  always_comb begin
    cand       = {overflow_in, carry_in, result_in[DATA_WIDTH-1], (result_in == '0)};
    wr_en      = status_wr ? wr_mask : 4'b0000;
    push_ok    = push && !pop && !stack_full;
    pop_ok     = pop && !push && !stack_empty;
    err_set    = (push && pop) || (push && stack_full) || (pop && stack_empty);
    flags_next = (flags & ~wr_en) | (cand & wr_en);
    count_next = stack_count;
    if (pop_ok) begin
      // A restore overrides any same-cycle flag write
      flags_next = stack_mem[pop_addr];
      count_next = stack_count - CW'(1);
    end else if (push_ok) begin
      count_next = stack_count + CW'(1);
    end
  end

  // Control state: flags, stack depth and sticky error; reset is asynchronous
  always_ff @(posedge clock or posedge status_reset) begin
    if (status_reset) begin
      flags       <= 4'b0000;
      stack_count <= '0;
      stack_error <= 1'b0;
    end else begin
      flags       <= flags_next;
      stack_count <= count_next;
      if (err_set) begin
        stack_error <= 1'b1;
      end else if (err_clr) begin
        stack_error <= 1'b0;
      end
    end
  end

  // Stack storage saves the pre-edge flags; entries are data only and never reset
  always_ff @(posedge clock) begin
    if (push_ok && !status_reset) begin
      stack_mem[push_addr] <= flags;
    end
  end

endmodule

// File: tb/tb_status_stack.sv
// Directed bench for status_stack: stimulus queues expected state, a monitor
// compares the DUT state after each edge (or on demand after async reset).
module tb_status_stack;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clock;
  logic          status_reset;
  logic [DW-1:0] result_in;
  logic          carry_in;
  logic          overflow_in;
  logic          status_wr;
  logic [3:0]    wr_mask;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic          flag_Z, flag_N, flag_C, flag_V;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_error;

  logic          chk;
  int            total;
  int            bad;

  string      name_q [$];
  logic [3:0] flag_q [$];
  int         cnt_q  [$];
  bit         err_q  [$];

  status_stack #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clock        (clock),
    .status_reset (status_reset),
    .result_in    (result_in),
    .carry_in     (carry_in),
    .overflow_in  (overflow_in),
    .status_wr    (status_wr),
    .wr_mask      (wr_mask),
    .push         (push),
    .pop          (pop),
    .err_clr      (err_clr),
    .flag_Z       (flag_Z),
    .flag_N       (flag_N),
    .flag_C       (flag_C),
    .flag_V       (flag_V),
    .stack_count  (stack_count),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_error  (stack_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string nm, input string field, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  task automatic expect_state(input string nm, input logic [3:0] ef, input int ec, input bit ee);
    name_q.push_back(nm);
    flag_q.push_back(ef);
    cnt_q.push_back(ec);
    err_q.push_back(ee);
  endtask

  // One clock of stimulus; expected values describe the state after the next rising edge
  task automatic cyc(input string nm, input bit wr, input logic [3:0] mask,
                     input logic [DW-1:0] res, input bit c, input bit v,
                     input bit pu, input bit po, input bit clr,
                     input logic [3:0] ef, input int ec, input bit ee);
    @(negedge clock);
    status_wr   = wr;
    wr_mask     = mask;
    result_in   = res;
    carry_in    = c;
    overflow_in = v;
    push        = pu;
    pop         = po;
    err_clr     = clr;
    expect_state(nm, ef, ec, ee);
  endtask

  task automatic idle_inputs();
    status_wr = 0; wr_mask = 0; result_in = 0; carry_in = 0;
    overflow_in = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  // Monitor: compares against the oldest queued expectation after each edge
  initial begin
    string      nm;
    logic [3:0] ef;
    int         ec;
    bit         ee;
    forever begin
      @(posedge clock or posedge chk);
      #1;
      if (name_q.size() > 0) begin
        nm = name_q.pop_front();
        ef = flag_q.pop_front();
        ec = cnt_q.pop_front();
        ee = err_q.pop_front();
        cmp(nm, "flags", int'({flag_V, flag_C, flag_N, flag_Z}), int'(ef));
        cmp(nm, "count", int'(stack_count), ec);
        cmp(nm, "full",  int'(stack_full),  int'(ec == DP));
        cmp(nm, "empty", int'(stack_empty), int'(ec == 0));
        cmp(nm, "error", int'(stack_error), int'(ee));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    chk   = 1'b0;
    status_reset = 1'b1;
    idle_inputs();
    #3;
    expect_state("reset", 4'b0000, 0, 0);
    chk = 1'b1;
    #1 chk = 1'b0;
    @(negedge clock);
    status_reset = 1'b0;

    // name           wr mask     result    c  v  pu po clr  flags    cnt err
    cyc("wr_all",      1, 4'hF,    16'h8000, 1, 0, 0, 0, 0,  4'b0110, 0, 0);
    cyc("wr_z_only",   1, 4'b0001, 16'h0000, 0, 1, 0, 0, 0,  4'b0111, 0, 0);
    cyc("wr_off",      0, 4'hF,    16'h0000, 1, 1, 0, 0, 0,  4'b0111, 0, 0);
    cyc("wr_mask0",    1, 4'b0000, 16'h0000, 1, 1, 0, 0, 0,  4'b0111, 0, 0);
    cyc("restore",     1, 4'hF,    16'h8000, 1, 0, 0, 0, 0,  4'b0110, 0, 0);
    cyc("push_wr",     1, 4'hF,    16'h0000, 0, 0, 1, 0, 0,  4'b0001, 1, 0);
    cyc("pop_wins",    1, 4'hF,    16'h8000, 1, 1, 0, 1, 0,  4'b0110, 0, 0);
    cyc("push1",       1, 4'hF,    16'h0001, 0, 1, 1, 0, 0,  4'b1000, 1, 0);
    cyc("push2",       1, 4'hF,    16'h0001, 1, 0, 1, 0, 0,  4'b0100, 2, 0);
    cyc("push3",       1, 4'hF,    16'h8001, 0, 1, 1, 0, 0,  4'b1010, 3, 0);
    cyc("push4",       1, 4'hF,    16'h0000, 1, 1, 1, 0, 0,  4'b1101, 4, 0);
    cyc("push5_full",  1, 4'hF,    16'h8000, 0, 0, 1, 0, 0,  4'b0010, 4, 1);
    cyc("pop1",        0, 4'h0,    16'h0000, 0, 0, 0, 1, 0,  4'b1010, 3, 1);
    cyc("pop2",        0, 4'h0,    16'h0000, 0, 0, 0, 1, 0,  4'b0100, 2, 1);
    cyc("pop3",        0, 4'h0,    16'h0000, 0, 0, 0, 1, 0,  4'b1000, 1, 1);
    cyc("pop4",        0, 4'h0,    16'h0000, 0, 0, 0, 1, 0,  4'b0110, 0, 1);
    cyc("pop5_empty",  1, 4'b1000, 16'h0000, 0, 1, 0, 1, 0,  4'b1110, 0, 1);
    cyc("err_clr",     0, 4'h0,    16'h0000, 0, 0, 0, 0, 1,  4'b1110, 0, 0);
    cyc("err_vs_clr",  0, 4'h0,    16'h0000, 0, 0, 1, 1, 1,  4'b1110, 0, 1);
    cyc("err_clr2",    0, 4'h0,    16'h0000, 0, 0, 0, 0, 1,  4'b1110, 0, 0);
    cyc("push_a",      1, 4'hF,    16'h0000, 0, 0, 1, 0, 0,  4'b0001, 1, 0);
    cyc("push_b",      0, 4'h0,    16'h0000, 0, 0, 1, 0, 0,  4'b0001, 2, 0);
    cyc("push_pop",    1, 4'hF,    16'h8000, 1, 0, 1, 1, 0,  4'b0110, 2, 1);
    cyc("err_clr3",    0, 4'h0,    16'h0000, 0, 0, 0, 0, 1,  4'b0110, 2, 0);
    cyc("pop_b",       0, 4'h0,    16'h0000, 0, 0, 0, 1, 0,  4'b0001, 1, 0);
    cyc("push_c",      1, 4'b1110, 16'h8000, 1, 1, 1, 0, 0,  4'b1111, 2, 0);
    cyc("push_d",      0, 4'h0,    16'h0000, 0, 0, 1, 0, 0,  4'b1111, 3, 0);

    // Async reset between edges while a push/write is being presented
    @(negedge clock);
    status_wr = 1; wr_mask = 4'hF; result_in = 16'h8000; carry_in = 1;
    overflow_in = 1; push = 1; pop = 0; err_clr = 0;
    #2;
    status_reset = 1'b1;
    expect_state("async_rst", 4'b0000, 0, 0);
    chk = 1'b1;
    #1 chk = 1'b0;
    #1;
    expect_state("rst_hold", 4'b0000, 0, 0);
    @(negedge clock);
    status_reset = 1'b0;
    idle_inputs();

    cyc("post_rst_push", 1, 4'hF,  16'h0000, 0, 0, 1, 0, 0,  4'b0001, 1, 0);
    cyc("post_rst_pop",  0, 4'h0,  16'h0000, 0, 0, 0, 1, 0,  4'b0000, 0, 0);

    @(negedge clock);
    idle_inputs();
    for (int i = 0; i < 20 && name_q.size() > 0; i++) @(negedge clock);
    if (name_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", name_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
